// File: rtl/ga_alu_issue.sv
// ga_alu_issue: loads word-serial GA operands, issues one ga_alu request, streams the 8-word result back.
package ga_pkg;
    localparam int GaWidth = 32;
    typedef enum logic [3:0] {
        GA_ADD, GA_SUB, GA_MUL, GA_WEDGE, GA_DOT, GA_DUAL, GA_REV, GA_NORM, GA_ROTATE, GA_REFLECT
    } ga_funct_e;
    // Declared MSB-first so a cast to [7:0][W-1:0] puts scalar at word index 0.
    typedef struct packed {
        logic [GaWidth-1:0] trivector, bivector_yz, bivector_xz, bivector_xy, vector_z, vector_y, vector_x, scalar;
    } ga_multivector_t;
endpackage

module ga_alu_issue #(
    parameter int DataWidth     = ga_pkg::GaWidth,
    parameter int TimeoutCycles = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     cmd_valid_i,
    output logic                     cmd_ready_o,
    input  ga_pkg::ga_funct_e        cmd_op_i,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    input  logic [DataWidth-1:0]     in_data_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [DataWidth-1:0]     out_data_o,
    output logic                     out_last_o,
    output logic                     alu_valid_o,
    input  logic                     alu_ready_i,
    output ga_pkg::ga_funct_e        alu_op_o,
    output ga_pkg::ga_multivector_t  alu_a_o,
    output ga_pkg::ga_multivector_t  alu_b_o,
    input  ga_pkg::ga_multivector_t  alu_result_i,
    output logic                     busy_o,
    output logic                     err_o
);
    import ga_pkg::*;
    localparam int TW = $clog2(TimeoutCycles + 1);
    typedef enum logic [2:0] {S_IDLE, S_LOAD_A, S_LOAD_B, S_ISSUE, S_WAIT, S_DRAIN} state_e;
    state_e                    r_state;
    ga_funct_e                 r_op;
    logic [7:0][DataWidth-1:0] r_a, r_b, r_res;
    logic [2:0]                r_cnt;
    logic [TW-1:0]             r_timer;
    logic                      r_seen_low, r_err;
    logic                      w_legal, w_unary;
    assign w_legal     = cmd_op_i <= GA_REFLECT;
    assign w_unary     = r_op == GA_DUAL || r_op == GA_REV || r_op == GA_NORM;
    assign cmd_ready_o = r_state == S_IDLE;
    assign busy_o      = r_state != S_IDLE;
    assign in_ready_o  = r_state == S_LOAD_A || r_state == S_LOAD_B;
    assign alu_valid_o = r_state == S_ISSUE;
    assign out_valid_o = r_state == S_DRAIN;
    assign out_last_o  = r_state == S_DRAIN && r_cnt == 3'd7;
    assign out_data_o  = r_res[r_cnt];
    assign alu_op_o    = r_op;
    assign alu_a_o     = r_a;
    assign alu_b_o     = r_b;
    assign err_o       = r_err;
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state    <= S_IDLE;
            r_op       <= GA_ADD;
            r_a        <= '0;
            r_b        <= '0;
            r_res      <= '0;
            r_cnt      <= '0;
            r_timer    <= '0;
            r_seen_low <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_err <= 1'b0;
            case (r_state)
                S_IDLE: if (cmd_valid_i) begin
                    if (w_legal) begin
                        r_op    <= cmd_op_i;
                        r_cnt   <= '0;
                        r_state <= S_LOAD_A;
                    end else begin
                        r_err <= 1'b1;
                    end
                end
                S_LOAD_A: if (in_valid_i) begin
                    r_a[r_cnt] <= in_data_i;
                    r_cnt      <= r_cnt + 3'd1;
                    if (r_cnt == 3'd7) begin
                        if (w_unary) r_b <= '0;
                        r_state <= w_unary ? S_ISSUE : S_LOAD_B;
                    end
                end
                S_LOAD_B: if (in_valid_i) begin
                    r_b[r_cnt] <= in_data_i;
                    r_cnt      <= r_cnt + 3'd1;
                    if (r_cnt == 3'd7) r_state <= S_ISSUE;
                end
                S_ISSUE: if (alu_ready_i) begin
                    r_seen_low <= 1'b0;
                    r_timer    <= '0;
                    r_state    <= S_WAIT;
                end
                S_WAIT: begin
                    // ga_alu must drop ready at least once before its result is trusted.
                    r_timer    <= r_timer + 1'b1;
                    r_seen_low <= r_seen_low | ~alu_ready_i;
                    if (r_seen_low && alu_ready_i) begin
                        r_res   <= alu_result_i;
                        r_state <= S_DRAIN;
                    end else if (r_timer == TW'(TimeoutCycles - 1)) begin
                        r_err   <= 1'b1;
                        r_state <= S_IDLE;
                    end
                end
                S_DRAIN: if (out_ready_i) begin
                    r_cnt <= r_cnt + 3'd1;
                    if (r_cnt == 3'd7) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ga_alu_issue.sv
// tb_ga_alu_issue: directed vector table plus hand sequences for timeout, illegal op and mid-drain reset.
module tb_ga_alu_issue;
    import ga_pkg::*;
    typedef logic [7:0][31:0] words_t;
    typedef struct {
        ga_funct_e op;
        words_t    a;
        words_t    b;
        words_t    e;
        bit        toggle;
        int        lat;
    } vec_t;

    logic            clk_i = 1'b0;
    logic            rst_ni;
    logic            cmd_valid_i, cmd_ready_o;
    ga_funct_e       cmd_op_i;
    logic            in_valid_i, in_ready_o;
    logic [31:0]     in_data_i;
    logic            out_valid_o, out_ready_i, out_last_o;
    logic [31:0]     out_data_o;
    logic            alu_valid_o, alu_ready_i;
    ga_funct_e       alu_op_o;
    ga_multivector_t alu_a_o, alu_b_o, alu_result_i;
    logic            busy_o, err_o;

    int n_vec = 0, n_err = 0;
    int hold_len = 1;
    int m_busy;
    int busy_cyc = 0, alu_v_cyc = 0, out_v_cyc = 0;
    vec_t vecs[4];

    always #5 clk_i = ~clk_i;

    ga_alu_issue dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_op_i(cmd_op_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_data_i(in_data_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_data_o(out_data_o), .out_last_o(out_last_o),
        .alu_valid_o(alu_valid_o), .alu_ready_i(alu_ready_i), .alu_op_o(alu_op_o),
        .alu_a_o(alu_a_o), .alu_b_o(alu_b_o), .alu_result_i(alu_result_i),
        .busy_o(busy_o), .err_o(err_o)
    );

    function automatic words_t alu_model(input ga_funct_e op, input words_t a, input words_t b);
        words_t r;
        for (int i = 0; i < 8; i++)
            case (op)
                GA_ADD:  r[i] = a[i] + b[i];
                GA_SUB:  r[i] = a[i] - b[i];
                GA_MUL:  r[i] = a[i] * b[i];
                GA_REV:  r[i] = i < 4 ? a[i] : -a[i];
                default: r[i] = a[i];
            endcase
        return r;
    endfunction

    // ga_alu stand-in: ready drops for hold_len cycles after each accepted request.
    always @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            alu_ready_i  <= 1'b1;
            m_busy       <= 0;
            alu_result_i <= '0;
        end else if (alu_valid_o && alu_ready_i) begin
            alu_ready_i  <= 1'b0;
            m_busy       <= hold_len;
            alu_result_i <= alu_model(alu_op_o, alu_a_o, alu_b_o);
        end else if (m_busy > 0) begin
            m_busy <= m_busy - 1;
            if (m_busy == 1) alu_ready_i <= 1'b1;
        end
    end

    always @(negedge clk_i) begin
        if (busy_o)      busy_cyc  <= busy_cyc + 1;
        if (alu_valid_o) alu_v_cyc <= alu_v_cyc + 1;
        if (out_valid_o) out_v_cyc <= out_v_cyc + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic send_cmd(input ga_funct_e op);
        cmd_valid_i = 1'b1;
        cmd_op_i    = op;
        @(negedge clk_i);
        cmd_valid_i = 1'b0;
    endtask

    task automatic load8(input words_t w);
        for (int i = 0; i < 8; i++) begin
            int t;
            t = 0;
            in_valid_i = 1'b1;
            in_data_i  = w[i];
            while (!in_ready_o && t < 20) begin
                @(negedge clk_i);
                t++;
            end
            if (!in_ready_o) check("load_ready_timeout", in_ready_o, 1);
            @(negedge clk_i);
        end
    endtask

    task automatic drain(input words_t e, input bit toggle, input int stop);
        int idx, t;
        idx = 0;
        t = 0;
        out_ready_i = !toggle;
        while (idx < stop && t < 200) begin
            if (toggle) out_ready_i = ~out_ready_i;
            if (out_valid_o) begin
                check($sformatf("out_data[%0d]", idx), out_data_o, e[idx]);
                check($sformatf("out_last[%0d]", idx), out_last_o, idx == 7);
                if (out_ready_i) idx++;
            end
            @(negedge clk_i);
            t++;
        end
        if (idx < stop) check("drain_timeout", idx, stop);
        out_ready_i = 1'b1;
    endtask

    task automatic run_vec(input vec_t v, input int stop);
        int b0, v0;
        b0 = busy_cyc;
        v0 = alu_v_cyc;
        send_cmd(v.op);
        load8(v.a);
        if (v.op == GA_DUAL || v.op == GA_REV || v.op == GA_NORM) begin
            in_valid_i = 1'b1;
            in_data_i  = 32'hDEAD_BEEF;
            check("unary_9th_in_ready", in_ready_o, 0);
            check("unary_b_cleared", {31'd0, |alu_b_o}, 0);
        end else begin
            load8(v.b);
        end
        in_valid_i = 1'b0;
        check("alu_op", alu_op_o, v.op);
        drain(v.e, v.toggle, stop);
        if (stop == 8) begin
            check("alu_valid_cycles", alu_v_cyc - v0, 1);
            check("idle_after", busy_o, 0);
            if (v.lat != 0) check("busy_latency", busy_cyc - b0, v.lat);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cmd_ready"}, cmd_ready_o, 1);
        check({tag, "_busy"}, busy_o, 0);
        check({tag, "_in_ready"}, in_ready_o, 0);
        check({tag, "_alu_valid"}, alu_valid_o, 0);
        check({tag, "_out_valid"}, out_valid_o, 0);
        check({tag, "_out_last"}, out_last_o, 0);
        check({tag, "_err"}, err_o, 0);
        check({tag, "_alu_a"}, {31'd0, |alu_a_o}, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int k, o0;
        vecs[0] = '{GA_ADD,
            {32'd8, 32'd7, 32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1},
            {32'd80, 32'd70, 32'd60, 32'd50, 32'd40, 32'd30, 32'd20, 32'd10},
            {32'd88, 32'd77, 32'd66, 32'd55, 32'd44, 32'd33, 32'd22, 32'd11}, 1'b0, 27};
        vecs[1] = '{GA_REV,
            {32'd8, 32'd7, 32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1},
            '0,
            {32'hFFFF_FFF8, 32'hFFFF_FFF9, 32'hFFFF_FFFA, 32'hFFFF_FFFB, 32'd4, 32'd3, 32'd2, 32'd1}, 1'b0, 19};
        vecs[2] = '{GA_MUL,
            {32'd8, 32'd7, 32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1},
            {32'd9, 32'd8, 32'd7, 32'd6, 32'd5, 32'd4, 32'd3, 32'd2},
            {32'd72, 32'd56, 32'd42, 32'd30, 32'd20, 32'd12, 32'd6, 32'd2}, 1'b1, 0};
        vecs[3] = '{GA_SUB,
            {32'd800, 32'd700, 32'd600, 32'd500, 32'd400, 32'd300, 32'd200, 32'd100},
            {32'd8, 32'd7, 32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1},
            {32'd792, 32'd693, 32'd594, 32'd495, 32'd396, 32'd297, 32'd198, 32'd99}, 1'b0, 27};
        rst_ni      = 1'b0;
        cmd_valid_i = 1'b0;
        cmd_op_i    = GA_ADD;
        in_valid_i  = 1'b0;
        in_data_i   = '0;
        out_ready_i = 1'b1;
        repeat (2) @(negedge clk_i);
        check_reset_outputs("reset");
        rst_ni = 1'b1;
        @(negedge clk_i);
        for (int i = 0; i < 4; i++) run_vec(vecs[i], 8);
        // Opcode outside the legal set: one-cycle error, never leaves IDLE.
        cmd_valid_i = 1'b1;
        cmd_op_i    = ga_funct_e'(4'hC);
        @(negedge clk_i);
        cmd_valid_i = 1'b0;
        check("illegal_err", err_o, 1);
        check("illegal_busy", busy_o, 0);
        @(negedge clk_i);
        check("illegal_err_pulse", err_o, 0);
        check("illegal_busy_after", busy_o, 0);
        // A second command during LOAD_A is neither accepted nor allowed to change the op.
        send_cmd(GA_ADD);
        cmd_valid_i = 1'b1;
        cmd_op_i    = GA_SUB;
        check("load_cmd_ready", cmd_ready_o, 0);
        load8(vecs[0].a);
        load8(vecs[0].b);
        cmd_valid_i = 1'b0;
        in_valid_i  = 1'b0;
        check("load_cmd_op_kept", alu_op_o, GA_ADD);
        drain(vecs[0].e, 1'b0, 8);
        // Stalled ga_alu: abort after the 16th WAIT cycle.
        hold_len = 20;
        send_cmd(GA_ADD);
        load8(vecs[0].a);
        load8(vecs[0].b);
        in_valid_i = 1'b0;
        o0 = out_v_cyc;
        k  = 0;
        check("to_issue", alu_valid_o, 1);
        while (!err_o && k < 40) begin
            @(negedge clk_i);
            k++;
        end
        check("to_err_cycle", k, 17);
        check("to_idle", busy_o, 0);
        @(negedge clk_i);
        check("to_err_pulse", err_o, 0);
        check("to_no_out_valid", out_v_cyc - o0, 0);
        repeat (10) @(negedge clk_i);
        hold_len = 1;
        // Reset while word 3 of the result is on the output.
        run_vec(vecs[0], 3);
        check("pre_reset_word3", out_data_o, 32'd44);
        rst_ni = 1'b0;
        #1;
        check_reset_outputs("midrst");
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        run_vec(vecs[0], 8);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
